// File: rtl/mix_columns_seq.sv
// mix_columns_seq: column-serial AES MixColumns with last-round bypass; MIX_COLUMNS_INV_EN adds the inv port for InvMixColumns.
module mix_columns_seq (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_data,
  input  logic         last_round,
`ifdef MIX_COLUMNS_INV_EN
  input  logic         inv,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_data,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, COMPUTE, DONE} state_t;
  state_t       r_state, w_next;
  logic [1:0]   r_col_cnt;
  logic [0:127] r_src, r_res;
  logic [31:0]  w_col, w_mix;

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_fwd(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

`ifdef MIX_COLUMNS_INV_EN
  logic r_inv;
  // c selects which of b, 2b, 4b, 8b are summed (09/0b/0d/0e all need 8b)
  function automatic logic [7:0] mul(input logic [7:0] b, input logic [3:0] c);
    logic [7:0] x2, x4, x8;
    x2 = xt(b);
    x4 = xt(x2);
    x8 = xt(x4);
    return (c[3] ? x8 : 8'h00) ^ (c[2] ? x4 : 8'h00) ^ (c[1] ? x2 : 8'h00) ^ (c[0] ? b : 8'h00);
  endfunction

  function automatic logic [31:0] mix_inv(input logic [31:0] a);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {mul(a0, 4'he) ^ mul(a1, 4'hb) ^ mul(a2, 4'hd) ^ mul(a3, 4'h9),
            mul(a0, 4'h9) ^ mul(a1, 4'he) ^ mul(a2, 4'hb) ^ mul(a3, 4'hd),
            mul(a0, 4'hd) ^ mul(a1, 4'h9) ^ mul(a2, 4'he) ^ mul(a3, 4'hb),
            mul(a0, 4'hb) ^ mul(a1, 4'hd) ^ mul(a2, 4'h9) ^ mul(a3, 4'he)};
  endfunction

  assign w_mix = r_inv ? mix_inv(w_col) : mix_fwd(w_col);
`else
  assign w_mix = mix_fwd(w_col);
`endif

  assign w_col    = r_src[{r_col_cnt, 5'd0} +: 32];
  assign out_data = r_res;

  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = !rst;
        busy     = 1'b0;
        if (in_valid && !rst) w_next = last_round ? DONE : COMPUTE;
      end
      COMPUTE: if (r_col_cnt == 2'd3) w_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_src     <= '0;
      r_res     <= '0;
      r_col_cnt <= '0;
`ifdef MIX_COLUMNS_INV_EN
      r_inv     <= 1'b0;
`endif
    end else if (r_state == IDLE && in_valid) begin
      r_src     <= in_data;
      r_col_cnt <= '0;
`ifdef MIX_COLUMNS_INV_EN
      r_inv     <= inv;
`endif
      if (last_round) r_res <= in_data;
    end else if (r_state == COMPUTE) begin
      r_res[{r_col_cnt, 5'd0} +: 32] <= w_mix;
      r_col_cnt                      <= r_col_cnt + 2'd1;
    end
endmodule

// File: tb/tb_mix_columns_seq.sv
// tb_mix_columns_seq: directed and random checks of mix_columns_seq against a GF(2^8) matrix model.
module tb_mix_columns_seq;
  logic         clk = 1'b0, rst = 1'b1, in_valid = 1'b0, last_round = 1'b0, out_ready = 1'b0, inv_i = 1'b0;
  logic         in_ready, out_valid, busy;
  logic [0:127] in_data = '0, out_data;
  int           n_cmp = 0, n_bad = 0;

  localparam logic [0:127] FIPS_IN  = 128'hdb135345_f20a225c_01010101_c6c6c6c6;
  localparam logic [0:127] FIPS_OUT = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6;
  localparam logic [0:127] BYP      = 128'h00112233_44556677_8899aabb_ccddeeff;

  always #5 clk = ~clk;

  mix_columns_seq dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .last_round(last_round),
`ifdef MIX_COLUMNS_INV_EN
    .inv(inv_i),
`endif
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  // carry-less polynomial product reduced modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = '0;
    for (int i = 0; i < 8; i++) if (b[i]) p ^= {8'h00, a} << i;
    for (int i = 15; i >= 8; i--) if (p[i]) p ^= 16'h011b << (i - 8);
    return p[7:0];
  endfunction

  function automatic logic [0:127] ref_mix(input logic [0:127] d, input logic lr, input logic iv);
    logic [7:0]   cf [4];
    logic [0:127] o;
    logic [7:0]   acc;
    if (lr) return d;
    if (iv) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    else    cf = '{8'h02, 8'h03, 8'h01, 8'h01};
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++) acc ^= gmul(cf[2'((k - r + 4) % 4)], d[7'(32 * c + 8 * k) +: 8]);
        o[7'(32 * c + 8 * r) +: 8] = acc;
      end
    return o;
  endfunction

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // starts and ends on a falling edge with the DUT idle
  task automatic run_block(input logic [0:127] d, input logic lr, input logic iv,
                           input logic [0:127] exp, input int exp_lat, input string tag);
    int k;
    in_data = d; last_round = lr; inv_i = iv; in_valid = 1'b1; out_ready = 1'b0;
    k = 0;
    while (!in_ready && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    k = 1;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    chk({tag, "_lat"}, k, exp_lat);
    chk({tag, "_data"}, out_data, exp);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin : main
    logic [0:127] v1, v2, held, d;
    logic [0:127] bd [8];
    logic         inv_at [8];
    logic         lr, iv;
    int           k, ai, oi, cyc, last_acc;

    @(negedge clk);
    @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    run_block(FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 5, "fips");
    run_block(BYP, 1'b1, 1'b0, BYP, 1, "bypass");

    v1 = {$urandom, $urandom, $urandom, $urandom};
    v2 = {$urandom, $urandom, $urandom, $urandom};
    in_data = v1; last_round = 1'b0; inv_i = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
    chk("bp_accept", in_ready, 1);
    @(negedge clk);
    in_data = v2;
    k = 1;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    chk("bp_lat", k, 5);
    held = out_data;
    chk("bp_data", held, ref_mix(v1, 1'b0, 1'b0));
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_ready", in_ready, 0);
      chk("bp_hold_data", out_data, held);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_idle_ready", in_ready, 1);
    chk("bp_idle_busy", busy, 0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_second_busy", busy, 1);
    k = 1;
    while (!out_valid && k < 20) begin @(negedge clk); k++; end
    chk("bp2_lat", k, 5);
    chk("bp2_data", out_data, ref_mix(v2, 1'b0, 1'b0));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    in_data = FIPS_IN; last_round = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_data", out_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", in_ready, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", in_ready, 1);
    chk("post_rst_valid", out_valid, 0);
    run_block(FIPS_IN, 1'b0, 1'b0, FIPS_OUT, 5, "post_rst");

    for (int i = 0; i < 4; i++) begin
      d  = {$urandom, $urandom, $urandom, $urandom};
      lr = 1'($urandom_range(0, 1));
`ifdef MIX_COLUMNS_INV_EN
      iv = 1'($urandom_range(0, 1));
`else
      iv = 1'b0;
`endif
      run_block(d, lr, iv, ref_mix(d, lr, iv), lr ? 1 : 5, "rand");
    end

    for (int i = 0; i < 8; i++) bd[i] = {$urandom, $urandom, $urandom, $urandom};
    ai = 0; oi = 0; cyc = 0; last_acc = 0;
    in_data = bd[0]; last_round = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
`ifdef MIX_COLUMNS_INV_EN
    inv_i = 1'($urandom_range(0, 1));
`endif
    while (oi < 8 && cyc < 300) begin
      if (out_valid) begin
        chk("b2b_data", out_data, ref_mix(bd[oi], 1'b0, inv_at[oi]));
        oi++;
      end
      if (in_valid && in_ready) begin
        if (ai > 0) chk("b2b_gap", cyc - last_acc, 6);
        inv_at[ai] = inv_i;
        last_acc = cyc;
        ai++;
      end else if (!in_ready) begin
        if (ai < 8) begin
          in_data = bd[ai];
`ifdef MIX_COLUMNS_INV_EN
          inv_i = 1'($urandom_range(0, 1));
`endif
        end else in_valid = 1'b0;
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; out_ready = 1'b0; inv_i = 1'b0;
    chk("b2b_count", oi, 8);
    @(negedge clk);

`ifdef MIX_COLUMNS_INV_EN
    run_block(FIPS_OUT, 1'b0, 1'b1, FIPS_IN, 5, "inv_fips");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/mix_columns_seq.md
# mix_columns_seq

Column-serial AES MixColumns stage that sits directly downstream of the row-shift stage in the encryption round datapath. It accepts the full 128-bit state over a valid/ready handshake and processes one 32-bit column per clock using four GF(2^8) multiply-accumulate lanes. It returns the mixed state on a held-output valid/ready handshake. A last-round flag bypasses mixing so the same stage serves the final AES round.

## Interface
- No parameters. Width fixed at 128-bit state, 4 columns of 4 bytes.
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  in_data/last_round valid
- in_ready  output  1  stage can accept a block
- in_data  input  [0:127]  state from row-shift stage; byte k = in_data[8k+:8], bit 8k is byte MSB; column c = bytes 4c..4c+3
- last_round  input  1  sampled with in_data; 1 = pass state through unmixed
- out_valid  output  1  out_data valid, held until accepted
- out_ready  input  1  downstream accepts out_data
- out_data  output  [0:127]  mixed state, same byte/column ordering as in_data
- busy  output  1  high in any state other than IDLE
- inv  input  1  present only with MIX_COLUMNS_INV_EN; sampled with in_data; 1 = InvMixColumns

## Operation
- States: IDLE, COMPUTE, DONE. col_cnt is 2 bits.
- IDLE:
  - in_ready = 1, except forced 0 while rst is high.
  - On in_valid && in_ready: latch in_data, last_round and inv into a source register; clear col_cnt.
  - If last_round = 1, next state is DONE and the result register gets in_data unchanged. Otherwise next state is COMPUTE.
- COMPUTE: each cycle mix column col_cnt of the source register into the same column of the result register, then increment col_cnt. When col_cnt = 3, next state is DONE.
- DONE: out_valid = 1 and out_data = result register, both held stable. On out_ready, next state is IDLE.
- in_ready is 0 in COMPUTE and DONE. in_valid is ignored there; blocks never overlap.
- Forward mix for column bytes a0..a3:
  - r0 = 2·a0 ^ 3·a1 ^ a2 ^ a3
  - r1 = a0 ^ 2·a1 ^ 3·a2 ^ a3
  - r2 = a0 ^ a1 ^ 2·a2 ^ 3·a3
  - r3 = 3·a0 ^ a1 ^ a2 ^ 2·a3
- Inverse mix uses coefficient rows {0e,0b,0d,09}, rotated per output byte in the same way.
- GF arithmetic:
  - xtime(b) = (b<<1)[7:0] ^ (b[7] ? 8'h1B : 8'h00).
  - 3·b = xtime(b) ^ b.
  - 9, 0b, 0d and 0e are built from xtime chains.
  - All results are 8-bit, no carries.
- Reset (asynchronous, any state, including mid-COMPUTE or while DONE is held):
  - State goes to IDLE, col_cnt = 0, out_valid = 0, out_data = 0, busy = 0.
  - Source and result registers clear to 0.
  - The partial block is discarded and is not re-emitted.

## Timing
- Reset values: in_ready 0 while rst is asserted, 1 on the first cycle after deassertion; out_valid 0; out_data 128'h0; busy 0.
- Normal block:
  - Accept edge at cycle 0.
  - COMPUTE on cycles 1–4 (columns 0–3).
  - out_valid first high in cycle 5.
  - Latency: 5 cycles from accept to out_valid.
- Last-round block: out_valid first high in cycle 1 (latency 1).
- Output accepted in cycle N: in_ready = 1 in cycle N+1.
- Peak throughput: one mixed block per 6 cycles.
- No combinational path from in_valid to in_ready, or from out_ready to out_valid.

## Configuration
- MIX_COLUMNS_INV_EN defined:
  - The inv port exists.
  - inv = 1 selects the InvMixColumns coefficients.
  - Latency and handshake are unchanged.
- MIX_COLUMNS_INV_EN undefined:
  - The inv port and the inverse multiplier logic are absent.
  - Only forward MixColumns is performed.

## Test plan
- FIPS-197 forward vector:
  - Stimulus: in_data = db135345_f20a225c_01010101_c6c6c6c6, last_round = 0.
  - Response: out_data = 8e4da1bc_9fdc589d_01010101_c6c6c6c6, with out_valid rising exactly 5 cycles after accept.
- Last-round bypass:
  - Stimulus: in_data = 00112233_44556677_8899aabb_ccddeeff, last_round = 1.
  - Response: identical out_data, with out_valid one cycle after accept.
- Backpressure:
  - Stimulus: hold out_ready = 0 for 10 cycles in DONE, and pulse in_valid during that time.
  - Response: out_data stable, out_valid = 1, in_ready = 0, and the second block is not accepted until the cycle after out_ready.
- Reset mid-operation:
  - Stimulus: assert rst during cycle 2 of COMPUTE.
  - Response: out_valid = 0 and out_data = 0 immediately. After release, in_ready = 1, and a fresh vector produces the correct result with no residue.
- Back-to-back blocks:
  - Stimulus: in_valid held high, out_ready held high, 8 random blocks.
  - Response: every output matches the reference model, with exactly 6 cycles between accepts.
- With MIX_COLUMNS_INV_EN:
  - Stimulus: inv = 1 on 8e4da1bc_9fdc589d_01010101_c6c6c6c6.
  - Response: out_data = db135345_f20a225c_01010101_c6c6c6c6.
